// File: rtl/fir_xifu_wb.sv
// Writeback stage of the FIR X-interface unit: holds one instruction, waits for load data,
// and ties the FIR regfile write and retirement to the X-interface result handshake.
module fir_xifu_wb #(
    parameter int unsigned NB_REGS  = 4,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ex_valid_i,
    output logic                ex_ready_o,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    input  logic [4:0]          ex_rd_i,
    input  logic [31:0]         ex_result_i,
    input  logic                ex_rf_we_i,
    input  logic                ex_core_we_i,
    input  logic                ex_is_load_i,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_rdata_i,
    input  logic                flush_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                wb_write_o,
    output logic [4:0]          wb_rd_o,
    output logic [31:0]         wb_result_o,
    output logic [31:0]         retired_o
);

    localparam int unsigned RfIdxW = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;

    typedef enum logic [1:0] {StIdle, StWaitMem, StResult, StDrain} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         data_q, data_d;
    logic                rf_we_q, rf_we_d;
    logic                core_we_q, core_we_d;
    logic [31:0]         retired_q, retired_d;

    logic accept;
    logic handshake;

    assign accept    = ex_valid_i & ex_ready_o;
    assign handshake = (state_q == StResult) & result_ready_i & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            id_q      <= '0;
            rd_q      <= '0;
            data_q    <= '0;
            rf_we_q   <= 1'b0;
            core_we_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
            rf_we_q   <= rf_we_d;
            core_we_q <= core_we_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = ex_is_load_i ? StWaitMem : StResult;
            end
            StWaitMem: begin
                if (flush_i)          state_d = StDrain;
                else if (mem_valid_i) state_d = StResult;
            end
            StResult: begin
                if (flush_i)             state_d = StIdle;
                else if (accept)         state_d = ex_is_load_i ? StWaitMem : StResult;
                else if (result_ready_i) state_d = StIdle;
            end
            StDrain: begin
                if (mem_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stray memory responses outside WAIT_MEM never touch the held data.
    always_comb begin
        id_d      = id_q;
        rd_d      = rd_q;
        data_d    = data_q;
        rf_we_d   = rf_we_q;
        core_we_d = core_we_q;
        retired_d = retired_q + {31'd0, handshake};
        if (accept) begin
            id_d      = ex_id_i;
            rd_d      = ex_rd_i;
            data_d    = ex_result_i;
            rf_we_d   = ex_rf_we_i;
            core_we_d = ex_core_we_i;
        end else if ((state_q == StWaitMem) && !flush_i && mem_valid_i) begin
            data_d = mem_rdata_i;
        end
    end

    always_comb begin
        ex_ready_o     = ~rst_i & ~flush_i &
                         ((state_q == StIdle) | ((state_q == StResult) & result_ready_i));
        result_valid_o = (state_q == StResult) & ~flush_i;
        result_id_o    = id_q;
        result_rd_o    = rd_q;
        result_data_o  = data_q;
        result_we_o    = core_we_q;
        wb_write_o     = handshake & rf_we_q;
        wb_rd_o        = 5'(rd_q[RfIdxW-1:0]);
        wb_result_o    = data_q;
        retired_o      = retired_q;
    end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Directed bench for fir_xifu_wb: inputs change 1ns after the rising edge and outputs are
// checked on the falling edge, so combinational outputs reflect the current cycle.
module tb_fir_xifu_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [3:0]  ex_id;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic        ex_rf_we, ex_core_we, ex_is_load;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        flush;
    logic        result_valid, result_ready;
    logic [3:0]  result_id;
    logic [31:0] result_data;
    logic [4:0]  result_rd;
    logic        result_we;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fir_xifu_wb #(.NB_REGS(4), .ID_WIDTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ex_valid_i     (ex_valid),
        .ex_ready_o     (ex_ready),
        .ex_id_i        (ex_id),
        .ex_rd_i        (ex_rd),
        .ex_result_i    (ex_result),
        .ex_rf_we_i     (ex_rf_we),
        .ex_core_we_i   (ex_core_we),
        .ex_is_load_i   (ex_is_load),
        .mem_valid_i    (mem_valid),
        .mem_rdata_i    (mem_rdata),
        .flush_i        (flush),
        .result_valid_o (result_valid),
        .result_ready_i (result_ready),
        .result_id_o    (result_id),
        .result_data_o  (result_data),
        .result_rd_o    (result_rd),
        .result_we_o    (result_we),
        .wb_write_o     (wb_write),
        .wb_rd_o        (wb_rd),
        .wb_result_o    (wb_result),
        .retired_o      (retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic v, input logic [3:0] id, input logic [4:0] rd,
                            input logic [31:0] res, input logic rf_we, input logic core_we,
                            input logic is_load);
        ex_valid   = v;
        ex_id      = id;
        ex_rd      = rd;
        ex_result  = res;
        ex_rf_we   = rf_we;
        ex_core_we = core_we;
        ex_is_load = is_load;
    endtask

    initial begin
        rst = 1'b1;
        drive_ex(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        mem_valid    = 1'b0;
        mem_rdata    = 32'd0;
        flush        = 1'b0;
        result_ready = 1'b1;

        // Reset state
        tick();
        mid();
        chk("rst_ex_ready", ex_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_wb_write", wb_write, 0);
        chk("rst_retired", retired, 0);
        tick();
        rst = 1'b0;
        mid();
        chk("idle_ex_ready", ex_ready, 1);

        // Single non-load, core always ready
        tick();
        drive_ex(1'b1, 4'd3, 5'd2, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        mid();
        chk("nl_accept", ex_ready, 1);
        tick();
        ex_valid = 1'b0;
        mid();
        chk("nl_result_valid", result_valid, 1);
        chk("nl_result_id", result_id, 3);
        chk("nl_result_rd", result_rd, 2);
        chk("nl_result_data", result_data, 32'h1234_5678);
        chk("nl_result_we", result_we, 1);
        chk("nl_wb_write", wb_write, 1);
        chk("nl_wb_rd", wb_rd, 2);
        chk("nl_wb_result", wb_result, 32'h1234_5678);
        tick();
        mid();
        chk("nl_retired", retired, 1);
        chk("nl_idle_valid", result_valid, 0);

        // Four back-to-back non-loads
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) drive_ex(1'b1, 4'(i + 4), 5'(i), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
            else       ex_valid = 1'b0;
            mid();
            chk("b2b_ex_ready", ex_ready, 1);
            if (i > 0) begin
                chk("b2b_wb_write", wb_write, 1);
                chk("b2b_wb_rd", wb_rd, 32'(i - 1));
                chk("b2b_wb_result", wb_result, 32'h100 + 32'(i - 1));
            end
        end
        tick();
        mid();
        chk("b2b_retired", retired, 5);

        // Backpressure: result held for 3 cycles
        drive_ex(1'b1, 4'd9, 5'd3, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0);
        result_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("bp_valid", result_valid, 1);
            chk("bp_id", result_id, 9);
            chk("bp_data", result_data, 32'hA5A5_A5A5);
            chk("bp_ex_ready", ex_ready, 0);
            chk("bp_wb_write", wb_write, 0);
            tick();
        end
        result_ready = 1'b1;
        mid();
        chk("bp_release_wb_write", wb_write, 1);
        chk("bp_release_wb_rd", wb_rd, 3);
        chk("bp_release_ex_ready", ex_ready, 1);
        tick();
        mid();
        chk("bp_retired", retired, 6);

        // Load with response 5 cycles after acceptance
        drive_ex(1'b1, 4'd5, 5'd1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
        tick();
        drive_ex(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("ld_wait_valid", result_valid, 0);
            chk("ld_wait_ex_ready", ex_ready, 0);
            tick();
        end
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        mid();
        chk("ld_resp_valid", result_valid, 0);
        tick();
        mem_valid = 1'b0;
        mem_rdata = 32'd0;
        mid();
        chk("ld_result_valid", result_valid, 1);
        chk("ld_result_data", result_data, 32'hCAFE_F00D);
        chk("ld_result_rd", result_rd, 1);
        chk("ld_wb_write", wb_write, 1);
        chk("ld_wb_result", wb_result, 32'hCAFE_F00D);
        tick();
        mid();
        chk("ld_retired", retired, 7);

        // Load flushed in WAIT_MEM, then drained
        drive_ex(1'b1, 4'd6, 5'd2, 32'd0, 1'b1, 1'b1, 1'b1);
        tick();
        drive_ex(1'b0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        mid();
        chk("fl_ex_ready", ex_ready, 0);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid();
            chk("drain_ex_ready", ex_ready, 0);
            chk("drain_valid", result_valid, 0);
            tick();
        end
        mem_valid = 1'b1;
        mem_rdata = 32'h1111_1111;
        mid();
        chk("drain_resp_ex_ready", ex_ready, 0);
        chk("drain_resp_wb_write", wb_write, 0);
        tick();
        mem_valid = 1'b0;
        mid();
        chk("drain_done_ex_ready", ex_ready, 1);
        chk("drain_done_valid", result_valid, 0);
        chk("drain_retired", retired, 7);

        // Stray response in IDLE and in RESULT is ignored
        mem_valid = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        mem_valid = 1'b0;
        mid();
        chk("stray_idle_ex_ready", ex_ready, 1);
        chk("stray_idle_valid", result_valid, 0);
        drive_ex(1'b1, 4'd7, 5'd0, 32'h33, 1'b1, 1'b0, 1'b0);
        result_ready = 1'b0;
        tick();
        ex_valid  = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'h44;
        tick();
        mem_valid = 1'b0;
        mid();
        chk("stray_res_valid", result_valid, 1);
        chk("stray_res_data", result_data, 32'h33);

        // Flush and ready together in RESULT: flush wins
        tick();
        drive_ex(1'b1, 4'd8, 5'd1, 32'h55, 1'b1, 1'b1, 1'b0);
        result_ready = 1'b1;
        flush        = 1'b1;
        mid();
        chk("fr_wb_write", wb_write, 0);
        chk("fr_ex_ready", ex_ready, 0);
        chk("fr_valid", result_valid, 0);
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        mid();
        chk("fr_no_accept", result_valid, 0);
        chk("fr_retired", retired, 7);

        // Retire counter wrap
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        chk("wrap_preset", retired, 32'hFFFF_FFFF);
        tick();
        drive_ex(1'b1, 4'd1, 5'd1, 32'h66, 1'b1, 1'b0, 1'b0);
        tick();
        ex_valid = 1'b0;
        mid();
        chk("wrap_wb_write", wb_write, 1);
        tick();
        mid();
        chk("wrap_retired", retired, 0);

        // Reset asserted while in RESULT
        drive_ex(1'b1, 4'hF, 5'h1F, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        result_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        mid();
        chk("rr_valid_before", result_valid, 1);
        rst = 1'b1;
        #1;
        chk("rr_ex_ready", ex_ready, 0);
        chk("rr_valid", result_valid, 0);
        chk("rr_id", result_id, 0);
        chk("rr_data", result_data, 0);
        chk("rr_rd", result_rd, 0);
        chk("rr_we", result_we, 0);
        chk("rr_wb_write", wb_write, 0);
        chk("rr_wb_rd", wb_rd, 0);
        chk("rr_wb_result", wb_result, 0);
        chk("rr_retired", retired, 0);
        tick();
        rst          = 1'b0;
        result_ready = 1'b1;
        mem_valid    = 1'b1;
        mem_rdata    = 32'h7777_7777;
        tick();
        mem_valid = 1'b0;
        mid();
        chk("post_rst_ex_ready", ex_ready, 1);
        chk("post_rst_valid", result_valid, 0);
        chk("post_rst_data", result_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
